// File: rtl/intersection_ctrl.sv
// Two-head intersection scheduler with all-red clearance, optional pedestrian walk and night flash.
// Optional feature macro: INTERSECTION_CTRL_PED_EN (WALK state, pending latch, walk lamp).
module intersection_ctrl #(
  parameter int unsigned GLOW_GREEN   = 10,
  parameter int unsigned GLOW_YELLOW  = 3,
  parameter int unsigned GLOW_ALL_RED = 2,
  parameter int unsigned GLOW_WALK    = 6,
  parameter int unsigned FLASH_HALF   = 4,
  parameter int unsigned COUNT_WIDTH  = 5
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ped_req,
  input  logic i_night,
  output logic o_a_red,
  output logic o_a_yellow,
  output logic o_a_green,
  output logic o_b_red,
  output logic o_b_yellow,
  output logic o_b_green,
  output logic o_walk,
  output logic o_ped_pending
);

  typedef enum logic [2:0] {
    CLR_A, A_GREEN, A_YELLOW, CLR_B, B_GREEN, B_YELLOW, WALK, FLASH
  } state_t;

  // A zero duration behaves as a single cycle.
  localparam int unsigned GREEN_N  = (GLOW_GREEN   == 0) ? 1 : GLOW_GREEN;
  localparam int unsigned YELLOW_N = (GLOW_YELLOW  == 0) ? 1 : GLOW_YELLOW;
  localparam int unsigned RED_N    = (GLOW_ALL_RED == 0) ? 1 : GLOW_ALL_RED;
  localparam int unsigned WALK_N   = (GLOW_WALK    == 0) ? 1 : GLOW_WALK;
  localparam int unsigned FLASH_N  = (FLASH_HALF   == 0) ? 1 : FLASH_HALF;

  localparam logic [COUNT_WIDTH-1:0] GREEN_LAST  = COUNT_WIDTH'(GREEN_N - 1);
  localparam logic [COUNT_WIDTH-1:0] YELLOW_LAST = COUNT_WIDTH'(YELLOW_N - 1);
  localparam logic [COUNT_WIDTH-1:0] RED_LAST    = COUNT_WIDTH'(RED_N - 1);
  localparam logic [COUNT_WIDTH-1:0] WALK_LAST   = COUNT_WIDTH'(WALK_N - 1);
  localparam logic [COUNT_WIDTH-1:0] FLASH_LAST  = COUNT_WIDTH'(FLASH_N - 1);

  state_t                 state, state_nx;
  logic [COUNT_WIDTH-1:0] cnt, cnt_nx;
  logic                   flash_on, flash_nx;
  logic [5:0]             lamps, lamps_nx;

`ifdef INTERSECTION_CTRL_PED_EN
  logic pending, pending_nx;
  logic walk_to_b, walk_to_b_nx;
  logic walk_q, pend_q;
`else
  logic unused_ped;
  assign unused_ped = i_ped_req;
  localparam logic [COUNT_WIDTH-1:0] UNUSED_WALK_LAST = WALK_LAST;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= CLR_A;
      cnt      <= '0;
      flash_on <= 1'b0;
`ifdef INTERSECTION_CTRL_PED_EN
      pending   <= 1'b0;
      walk_to_b <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      flash_on <= flash_nx;
`ifdef INTERSECTION_CTRL_PED_EN
      pending   <= pending_nx;
      walk_to_b <= walk_to_b_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    flash_nx = flash_on;
`ifdef INTERSECTION_CTRL_PED_EN
    // Requests during WALK are dropped; entering WALK clears the latch below.
    pending_nx   = pending | (i_ped_req & (state != WALK));
    walk_to_b_nx = walk_to_b;
`endif
    case (state)
      CLR_A, CLR_B: begin
        if (cnt == RED_LAST) begin
          cnt_nx = '0;
          if (i_night) begin
            state_nx = FLASH;
            flash_nx = 1'b1;
          end
`ifdef INTERSECTION_CTRL_PED_EN
          else if (pending) begin
            state_nx     = WALK;
            walk_to_b_nx = (state == CLR_B);
            pending_nx   = 1'b0;
          end
`endif
          else begin
            state_nx = (state == CLR_B) ? B_GREEN : A_GREEN;
          end
        end
      end
      A_GREEN: if (cnt == GREEN_LAST) begin
        state_nx = A_YELLOW;
        cnt_nx   = '0;
      end
      A_YELLOW: if (cnt == YELLOW_LAST) begin
        state_nx = CLR_B;
        cnt_nx   = '0;
      end
      B_GREEN: if (cnt == GREEN_LAST) begin
        state_nx = B_YELLOW;
        cnt_nx   = '0;
      end
      B_YELLOW: if (cnt == YELLOW_LAST) begin
        state_nx = CLR_A;
        cnt_nx   = '0;
      end
`ifdef INTERSECTION_CTRL_PED_EN
      WALK: if (cnt == WALK_LAST) begin
        state_nx = walk_to_b ? B_GREEN : A_GREEN;
        cnt_nx   = '0;
      end
`endif
      FLASH: if (cnt == FLASH_LAST) begin
        cnt_nx = '0;
        // Leave only after a complete dark half-period.
        if (flash_on) begin
          flash_nx = 1'b0;
        end else if (!i_night) begin
          state_nx = CLR_A;
        end else begin
          flash_nx = 1'b1;
        end
      end
      default: begin
        state_nx = CLR_A;
        cnt_nx   = '0;
      end
    endcase
  end

  // Lamp order: {a_red, a_yellow, a_green, b_red, b_yellow, b_green}.
  always_comb begin
    lamps_nx = 6'b100_100;
    case (state)
      A_GREEN:  lamps_nx = 6'b001_100;
      A_YELLOW: lamps_nx = 6'b010_100;
      B_GREEN:  lamps_nx = 6'b100_001;
      B_YELLOW: lamps_nx = 6'b100_010;
      FLASH:    lamps_nx = {1'b0, flash_on, 1'b0, 1'b0, flash_on, 1'b0};
      default:  lamps_nx = 6'b100_100;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lamps <= 6'b100_100;
    end else begin
      lamps <= lamps_nx;
    end
  end

`ifdef INTERSECTION_CTRL_PED_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      walk_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      walk_q <= (state == WALK);
      pend_q <= pending;
    end
  end
  assign o_walk        = walk_q;
  assign o_ped_pending = pend_q;
`else
  assign o_walk        = 1'b0;
  assign o_ped_pending = 1'b0;
`endif

  assign {o_a_red, o_a_yellow, o_a_green, o_b_red, o_b_yellow, o_b_green} = lamps;

endmodule
